hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core: stalls, flushes, forwarding selects.
//  Sits beside the decode stage and sees decode-stage register fields and control.
//  Keeps its own shadow pipeline of E/M/W destination records.
//  Detects load-use and decode-branch hazards, drives stall/flush enables and forwarding muxes.
// PARAMETERS
//  REG_AW  5   register address width
//  CNT_W   16  width of saturating hazard-stall cycle counter
// PORTS
//  i_clk          in   1       clock, all state on posedge
//  i_nrst         in   1       asynchronous active-low reset
//  i_addr_rs      in   REG_AW  decode-stage rs field
//  i_addr_rt      in   REG_AW  decode-stage rt field
//  i_con_use_rs   in   1       decode instr reads rs
//  i_con_use_rt   in   1       decode instr reads rt
//  i_con_dbranch  in   1       decode instr compares rs/rt in D (branch/jr)
//  i_addr_ddst    in   REG_AW  decode instr destination (regdst already resolved)
//  i_con_dregwr   in   1       decode instr writes a register
//  i_con_dmemrd   in   1       decode instr is a load
//  i_con_taken    in   1       branch/jump resolved taken in D this cycle
//  i_con_memstall in   1       data memory busy: freeze whole pipeline
//  i_con_cntclr   in   1       synchronous clear of stall counter
//  o_con_stallF   out  1       hold PC
//  o_con_stallD   out  1       hold F/D register
//  o_con_flushD   out  1       clear F/D register (taken branch)
//  o_con_flushE   out  1       insert bubble into D/E register
//  o_con_fwdD_rs  out  2       D compare operand rs select: 00 regbank, 01 W, 10 M
//  o_con_fwdD_rt  out  2       same for rt
//  o_con_fwdE_rs  out  2       E ALU operand rs select: 00 D/E reg, 01 W, 10 M
//  o_con_fwdE_rt  out  2       same for rt
//  o_cnt_stall    out  CNT_W   hazard stall cycles since reset/clear
// BEHAVIOUR
//  Shadow records E, M, W: {dst, regwr, memrd, rs, rt}. Reset: all fields 0 (regwr=0 => no hazards).
//  Each posedge, unless memstall: W<=M, M<=E, E<=(flushE ? bubble : D fields). memstall holds all.
//  Register 0 never matches; a record matches only when regwr=1 and dst!=0.
//  Load-use: E.memrd & E matches a used D source -> hazard.
//  Branch: dbranch & (E matches used source, any type) -> hazard; dbranch & M.memrd & M match -> hazard.
//   A load feeding a branch stalls 2 cycles (E then M); an ALU result feeding a branch stalls 1.
//  hazard=1: stallF=stallD=1, flushE=1 (E gets bubble), flushD=0 even if taken.
//  memstall=1: stallF=stallD=1, flushE=0, flushD=0; memstall has priority over hazard, and
//   the counter does not increment.
//  flushD = taken & ~hazard & ~memstall.
//  fwdE: M match on E.rs/rt & ~M.memrd -> 10; else W match -> 01; else 00. M has priority over W.
//  fwdD: same rule against D sources (regbank is write-at-edge, so W forwarding is needed).
//  All outputs except o_cnt_stall are combinational from the shadow and inputs, 0-cycle latency.
//   After reset, all outputs are 0.
//  Counter: +1 per cycle with hazard & ~memstall; saturates at all-ones.
//   cntclr wins over an increment in the same cycle. Reset value 0.
//  Async reset mid-operation clears the shadow at once; stalls and forwards drop the same cycle.
// STRUCTURE
//  arc_pkg: fwd_sel_e {FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10}; stage_rec_t struct;
//   REG_ZERO constant.
//  One sub-module hz_shadow_pipe: E/M/W stage_rec_t registers with hold/bubble control.
//  Top level holds the match/hazard logic, forwarding priority mux and counter.
// TESTING
//  lw $2 then add $3,$2,$4 -> one cycle with stallF=stallD=flushE=1, then fwdE_rs=10 is illegal
//   (load is in W) => fwdE_rs=01; cnt=1.
//  add $2 then beq $2,$5 -> one stall cycle, next cycle fwdD_rs=10; lw $2 then beq $2 -> two stall cycles.
//  add $0,... then add $3,$0,$0 -> no stall, all fwd=00.
//  add $2 in M and W (two writers) with use of $2 in E -> fwdE_rs=10 (M priority).
//  memstall held 3 cycles during a load-use hazard -> flushE=0, shadow frozen, cnt unchanged;
//   hazard resolves after release.
//  taken jump with no hazard -> flushD=1; cnt at 16'hFFFF + hazard stays FFFF;
//   cntclr with hazard -> 0; nrst low mid-stall -> all outputs 0 at once.

Source files
------------

// File: rtl/arc_pkg.sv
// Shared types for the pipeline sequencing controller: stage records, forwarding selects
// and register-match helpers.
package arc_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              regwr;
    logic              memrd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '0;

  // A record produces a value for addr only if it writes a non-zero destination equal to addr.
  function automatic logic rec_hit(input logic regwr, input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] addr);
    return regwr && (dst != REG_ZERO) && (dst == addr);
  endfunction

  // Youngest ALU result wins; a load still in M has no data yet, so fall through to W.
  function automatic fwd_sel_e fwd_pick(input logic m_regwr, input logic [REG_AW-1:0] m_dst,
                                        input logic m_memrd, input logic w_regwr,
                                        input logic [REG_AW-1:0] w_dst,
                                        input logic [REG_AW-1:0] addr);
    fwd_sel_e sel;
    sel = FWD_REG;
    if (rec_hit(m_regwr, m_dst, addr) && !m_memrd) begin
      sel = FWD_M;
    end else if (rec_hit(w_regwr, w_dst, addr)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hz_shadow_pipe.sv
// Shadow copy of the E/M/W destination records, advanced in step with the datapath.
module hz_shadow_pipe
  import arc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       hold,
  input  logic       bubble,
  input  stage_rec_t rec_d,
  output stage_rec_t rec_e,
  output stage_rec_t rec_m,
  output stage_rec_t rec_w
);

  // Hold freezes every stage; bubble only replaces what enters E.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rec_e <= REC_BUBBLE;
      rec_m <= REC_BUBBLE;
      rec_w <= REC_BUBBLE;
    end else if (!hold) begin
      rec_w <= rec_m;
      rec_m <= rec_e;
      rec_e <= bubble ? REC_BUBBLE : rec_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use / decode-branch hazard detection, stall and
// flush enables, forwarding selects and a saturating hazard-stall counter.
module hazard_ctrl
  import arc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic [REG_AW-1:0] i_addr_rs,
  input  logic [REG_AW-1:0] i_addr_rt,
  input  logic              i_con_use_rs,
  input  logic              i_con_use_rt,
  input  logic              i_con_dbranch,
  input  logic [REG_AW-1:0] i_addr_ddst,
  input  logic              i_con_dregwr,
  input  logic              i_con_dmemrd,
  input  logic              i_con_taken,
  input  logic              i_con_memstall,
  input  logic              i_con_cntclr,
  output logic              o_con_stallF,
  output logic              o_con_stallD,
  output logic              o_con_flushD,
  output logic              o_con_flushE,
  output logic [1:0]        o_con_fwdD_rs,
  output logic [1:0]        o_con_fwdD_rt,
  output logic [1:0]        o_con_fwdE_rs,
  output logic [1:0]        o_con_fwdE_rt,
  output logic [CNT_W-1:0]  o_cnt_stall
);

  stage_rec_t       rec_d, rec_e, rec_m, rec_w;
  logic             hit_e, hit_m, hazard, bubble_e;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_fields;

  assign rec_d = '{dst: i_addr_ddst, regwr: i_con_dregwr, memrd: i_con_dmemrd,
                   rs: i_addr_rs, rt: i_addr_rt};

  assign bubble_e = hazard && !i_con_memstall;

  hz_shadow_pipe u_shadow (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .hold   (i_con_memstall),
    .bubble (bubble_e),
    .rec_d  (rec_d),
    .rec_e  (rec_e),
    .rec_m  (rec_m),
    .rec_w  (rec_w)
  );

  // A load in M only blocks a D-stage compare; E-stage users get it from W after one bubble.
  always_comb begin
    hit_e  = 1'b0;
    hit_m  = 1'b0;
    hazard = 1'b0;
    hit_e  = (i_con_use_rs && rec_hit(rec_e.regwr, rec_e.dst, i_addr_rs)) ||
             (i_con_use_rt && rec_hit(rec_e.regwr, rec_e.dst, i_addr_rt));
    hit_m  = (i_con_use_rs && rec_hit(rec_m.regwr, rec_m.dst, i_addr_rs)) ||
             (i_con_use_rt && rec_hit(rec_m.regwr, rec_m.dst, i_addr_rt));
    hazard = (rec_e.memrd && hit_e) ||
             (i_con_dbranch && hit_e) ||
             (i_con_dbranch && rec_m.memrd && hit_m);
  end

  assign o_con_stallF = i_con_memstall || hazard;
  assign o_con_stallD = i_con_memstall || hazard;
  assign o_con_flushE = bubble_e;
  assign o_con_flushD = i_con_taken && !hazard && !i_con_memstall;

  assign o_con_fwdD_rs = 2'(fwd_pick(rec_m.regwr, rec_m.dst, rec_m.memrd,
                                     rec_w.regwr, rec_w.dst, i_addr_rs));
  assign o_con_fwdD_rt = 2'(fwd_pick(rec_m.regwr, rec_m.dst, rec_m.memrd,
                                     rec_w.regwr, rec_w.dst, i_addr_rt));
  assign o_con_fwdE_rs = 2'(fwd_pick(rec_m.regwr, rec_m.dst, rec_m.memrd,
                                     rec_w.regwr, rec_w.dst, rec_e.rs));
  assign o_con_fwdE_rt = 2'(fwd_pick(rec_m.regwr, rec_m.dst, rec_m.memrd,
                                     rec_w.regwr, rec_w.dst, rec_e.rt));

  // Clear beats increment; saturates at all-ones.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt_q <= '0;
    end else if (i_con_cntclr) begin
      cnt_q <= '0;
    end else if (bubble_e && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_cnt_stall = cnt_q;

  assign unused_fields = ^{rec_m.rs, rec_m.rt, rec_w.rs, rec_w.rt, rec_w.memrd};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic against a
// behavioural E/M/W model; a 4-bit-counter instance exercises saturation.
module tb_hazard_ctrl;

  logic       i_clk = 1'b0;
  logic       i_nrst = 1'b1;
  logic [4:0] i_addr_rs, i_addr_rt, i_addr_ddst;
  logic       i_con_use_rs, i_con_use_rt, i_con_dbranch, i_con_dregwr, i_con_dmemrd;
  logic       i_con_taken, i_con_memstall, i_con_cntclr;
  logic       o_con_stallF, o_con_stallD, o_con_flushD, o_con_flushE;
  logic [1:0] o_con_fwdD_rs, o_con_fwdD_rt, o_con_fwdE_rs, o_con_fwdE_rt;
  logic [15:0] o_cnt_stall;
  logic       s_stallF, s_stallD, s_flushD, s_flushE;
  logic [1:0] s_fwdD_rs, s_fwdD_rt, s_fwdE_rs, s_fwdE_rt;
  logic [3:0] s_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: index 0 = E, 1 = M, 2 = W.
  int m_dst[3], m_wr[3], m_ld[3], m_rs[3], m_rt[3];
  int n_dst[3], n_wr[3], n_ld[3], n_rs[3], n_rt[3];
  int m_cnt = 0, m_cnt4 = 0, n_cnt = 0, n_cnt4 = 0;

  hazard_ctrl #(.CNT_W(16)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_addr_rs(i_addr_rs), .i_addr_rt(i_addr_rt),
    .i_con_use_rs(i_con_use_rs), .i_con_use_rt(i_con_use_rt), .i_con_dbranch(i_con_dbranch),
    .i_addr_ddst(i_addr_ddst), .i_con_dregwr(i_con_dregwr), .i_con_dmemrd(i_con_dmemrd),
    .i_con_taken(i_con_taken), .i_con_memstall(i_con_memstall), .i_con_cntclr(i_con_cntclr),
    .o_con_stallF(o_con_stallF), .o_con_stallD(o_con_stallD), .o_con_flushD(o_con_flushD),
    .o_con_flushE(o_con_flushE), .o_con_fwdD_rs(o_con_fwdD_rs), .o_con_fwdD_rt(o_con_fwdD_rt),
    .o_con_fwdE_rs(o_con_fwdE_rs), .o_con_fwdE_rt(o_con_fwdE_rt), .o_cnt_stall(o_cnt_stall)
  );

  hazard_ctrl #(.CNT_W(4)) dut_small (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_addr_rs(i_addr_rs), .i_addr_rt(i_addr_rt),
    .i_con_use_rs(i_con_use_rs), .i_con_use_rt(i_con_use_rt), .i_con_dbranch(i_con_dbranch),
    .i_addr_ddst(i_addr_ddst), .i_con_dregwr(i_con_dregwr), .i_con_dmemrd(i_con_dmemrd),
    .i_con_taken(i_con_taken), .i_con_memstall(i_con_memstall), .i_con_cntclr(i_con_cntclr),
    .o_con_stallF(s_stallF), .o_con_stallD(s_stallD), .o_con_flushD(s_flushD),
    .o_con_flushE(s_flushE), .o_con_fwdD_rs(s_fwdD_rs), .o_con_fwdD_rt(s_fwdD_rt),
    .o_con_fwdE_rs(s_fwdE_rs), .o_con_fwdE_rt(s_fwdE_rt), .o_cnt_stall(s_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit wr_hit(input int k, input int a);
    return (m_wr[k] != 0) && (m_dst[k] != 0) && (m_dst[k] == a);
  endfunction

  function automatic int fwd_of(input int a);
    if (wr_hit(1, a) && m_ld[1] == 0) return 2;
    if (wr_hit(2, a)) return 1;
    return 0;
  endfunction

  function automatic bit model_haz();
    int a[2];
    bit u[2];
    bit r;
    r = 1'b0;
    a[0] = int'(i_addr_rs); u[0] = i_con_use_rs;
    a[1] = int'(i_addr_rt); u[1] = i_con_use_rt;
    for (int s = 0; s < 2; s++) begin
      if (u[s]) begin
        if (wr_hit(0, a[s]) && (m_ld[0] != 0 || i_con_dbranch)) r = 1'b1;
        if (i_con_dbranch && m_ld[1] != 0 && wr_hit(1, a[s])) r = 1'b1;
      end
    end
    return r;
  endfunction

  // Per-cycle compare against the model, then prepare its next state.
  always @(negedge i_clk) begin
    bit haz, ms;
    haz = model_haz();
    ms  = i_con_memstall;
    chk("stallF", int'(o_con_stallF), int'(ms | haz));
    chk("stallD", int'(o_con_stallD), int'(ms | haz));
    chk("flushE", int'(o_con_flushE), int'(haz & ~ms));
    chk("flushD", int'(o_con_flushD), int'(i_con_taken & ~haz & ~ms));
    chk("fwdD_rs", int'(o_con_fwdD_rs), fwd_of(int'(i_addr_rs)));
    chk("fwdD_rt", int'(o_con_fwdD_rt), fwd_of(int'(i_addr_rt)));
    chk("fwdE_rs", int'(o_con_fwdE_rs), fwd_of(m_rs[0]));
    chk("fwdE_rt", int'(o_con_fwdE_rt), fwd_of(m_rt[0]));
    chk("cnt", int'(o_cnt_stall), m_cnt);
    chk("cnt4", int'(s_cnt), m_cnt4);
    n_dst = m_dst; n_wr = m_wr; n_ld = m_ld; n_rs = m_rs; n_rt = m_rt;
    if (!ms) begin
      for (int k = 2; k > 0; k--) begin
        n_dst[k] = m_dst[k-1]; n_wr[k] = m_wr[k-1]; n_ld[k] = m_ld[k-1];
        n_rs[k] = m_rs[k-1]; n_rt[k] = m_rt[k-1];
      end
      if (haz) begin
        n_dst[0] = 0; n_wr[0] = 0; n_ld[0] = 0; n_rs[0] = 0; n_rt[0] = 0;
      end else begin
        n_dst[0] = int'(i_addr_ddst); n_wr[0] = int'(i_con_dregwr);
        n_ld[0] = int'(i_con_dmemrd); n_rs[0] = int'(i_addr_rs); n_rt[0] = int'(i_addr_rt);
      end
    end
    n_cnt  = i_con_cntclr ? 0 : ((haz && !ms && m_cnt < 65535) ? m_cnt + 1 : m_cnt);
    n_cnt4 = i_con_cntclr ? 0 : ((haz && !ms && m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4);
  end

  always @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int k = 0; k < 3; k++) begin
        m_dst[k] <= 0; m_wr[k] <= 0; m_ld[k] <= 0; m_rs[k] <= 0; m_rt[k] <= 0;
      end
      m_cnt  <= 0;
      m_cnt4 <= 0;
    end else begin
      m_dst <= n_dst; m_wr <= n_wr; m_ld <= n_ld; m_rs <= n_rs; m_rt <= n_rt;
      m_cnt  <= n_cnt;
      m_cnt4 <= n_cnt4;
    end
  end

  task automatic set_d(input int rs, input int rt, input int urs, input int urt, input int br,
                       input int dst, input int wr, input int ld);
    i_addr_rs = 5'(rs); i_addr_rt = 5'(rt);
    i_con_use_rs = 1'(urs); i_con_use_rt = 1'(urt); i_con_dbranch = 1'(br);
    i_addr_ddst = 5'(dst); i_con_dregwr = 1'(wr); i_con_dmemrd = 1'(ld);
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    nop();
    i_con_taken = 1'b0; i_con_memstall = 1'b0; i_con_cntclr = 1'b0;
    #1 i_nrst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_nrst = 1'b1;

    @(negedge i_clk);
    chk("rst_stall", int'(o_con_stallF | o_con_stallD | o_con_flushE | o_con_flushD), 0);
    chk("rst_fwd", int'({o_con_fwdD_rs, o_con_fwdD_rt, o_con_fwdE_rs, o_con_fwdE_rt}), 0);
    chk("rst_cnt", int'(o_cnt_stall), 0);
    tick();

    // lw $2 ; add $3,$2,$4
    set_d(1, 0, 1, 0, 0, 2, 1, 1); tick();
    set_d(2, 4, 1, 1, 0, 3, 1, 0);
    @(negedge i_clk);
    chk("lu_stall", int'({o_con_stallF, o_con_stallD, o_con_flushE}), 7);
    tick();
    @(negedge i_clk); chk("lu_release", int'(o_con_stallF), 0); tick();
    nop();
    @(negedge i_clk); chk("lu_fwdE_W", int'(o_con_fwdE_rs), 1); chk("lu_cnt", int'(o_cnt_stall), 1);
    tick(); drain();

    // add $2 ; beq $2,$5
    set_d(6, 7, 1, 1, 0, 2, 1, 0); tick();
    set_d(2, 5, 1, 1, 1, 0, 0, 0);
    @(negedge i_clk); chk("alu_br_stall", int'(o_con_stallD), 1); tick();
    @(negedge i_clk); chk("alu_br_go", int'(o_con_stallD), 0); chk("alu_br_fwdD", int'(o_con_fwdD_rs), 2);
    tick(); drain();

    // lw $2 ; beq $2,$5 taken: two stall cycles, no flushD until resolved
    set_d(1, 0, 1, 0, 0, 2, 1, 1); tick();
    set_d(2, 5, 1, 1, 1, 0, 0, 0); i_con_taken = 1'b1;
    @(negedge i_clk); chk("ld_br_stall1", int'(o_con_stallF), 1); chk("ld_br_noflushD1", int'(o_con_flushD), 0); tick();
    @(negedge i_clk); chk("ld_br_stall2", int'(o_con_stallF), 1); chk("ld_br_noflushD2", int'(o_con_flushD), 0); tick();
    @(negedge i_clk); chk("ld_br_go", int'(o_con_stallF), 0); chk("ld_br_flushD", int'(o_con_flushD), 1);
    chk("ld_br_fwdD", int'(o_con_fwdD_rs), 1);
    tick(); i_con_taken = 1'b0; drain();

    // add $0 ; add $3,$0,$0
    set_d(1, 1, 1, 1, 0, 0, 1, 0); tick();
    set_d(0, 0, 1, 1, 0, 3, 1, 0);
    @(negedge i_clk); chk("r0_stall", int'(o_con_stallF), 0);
    chk("r0_fwdD", int'({o_con_fwdD_rs, o_con_fwdD_rt}), 0); tick();
    nop();
    @(negedge i_clk); chk("r0_fwdE", int'({o_con_fwdE_rs, o_con_fwdE_rt}), 0); tick(); drain();

    // two writers of $2 in M and W
    set_d(0, 0, 0, 0, 0, 2, 1, 0); tick(); tick();
    set_d(2, 0, 1, 1, 0, 5, 1, 0); tick();
    nop();
    @(negedge i_clk); chk("mprio_fwdE", int'(o_con_fwdE_rs), 2); tick(); drain();

    // memstall during a load-use hazard
    i_con_cntclr = 1'b1; tick(); i_con_cntclr = 1'b0;
    set_d(1, 0, 1, 0, 0, 2, 1, 1);
    @(negedge i_clk); chk("ms_cnt_clr", int'(o_cnt_stall), 0); tick();
    set_d(2, 4, 1, 1, 0, 3, 1, 0); i_con_memstall = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("ms_stall", int'({o_con_stallF, o_con_stallD, o_con_flushE}), 6);
      chk("ms_cnt", int'(o_cnt_stall), 0);
      tick();
    end
    i_con_memstall = 1'b0;
    @(negedge i_clk); chk("ms_hazard_after", int'(o_con_flushE), 1); tick();
    @(negedge i_clk); chk("ms_resolved", int'(o_con_stallF), 0); chk("ms_cnt1", int'(o_cnt_stall), 1);
    tick(); drain();

    // taken jump, no hazard
    i_con_taken = 1'b1;
    @(negedge i_clk); chk("jmp_flushD", int'(o_con_flushD), 1); tick();
    i_con_taken = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      set_d(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 4) < 3), int'($urandom_range(0, 9) < 3));
      i_con_taken    = ($urandom_range(0, 6) == 0);
      i_con_memstall = ($urandom_range(0, 6) == 0);
      i_con_cntclr   = ($urandom_range(0, 49) == 0);
      tick();
    end
    i_con_taken = 1'b0; i_con_memstall = 1'b0; i_con_cntclr = 1'b0;
    drain();

    // saturation of the 4-bit counter instance
    i_con_cntclr = 1'b1; tick(); i_con_cntclr = 1'b0;
    repeat (20) begin
      set_d(1, 0, 1, 0, 0, 2, 1, 1); tick();
      set_d(2, 0, 1, 0, 0, 3, 1, 0); tick();
      nop(); tick();
    end
    @(negedge i_clk); chk("sat_cnt4", int'(s_cnt), 15); chk("sat_cnt16", int'(o_cnt_stall), 20);
    tick();
    set_d(1, 0, 1, 0, 0, 2, 1, 1); tick();
    set_d(2, 0, 1, 0, 0, 3, 1, 0);
    @(negedge i_clk); chk("sat_haz", int'(s_stallF), 1); tick();
    @(negedge i_clk); chk("sat_hold", int'(s_cnt), 15); tick(); drain();
    set_d(1, 0, 1, 0, 0, 2, 1, 1); tick();
    set_d(2, 0, 1, 0, 0, 3, 1, 0); i_con_cntclr = 1'b1;
    @(negedge i_clk); chk("clr_haz", int'(o_con_flushE), 1); tick();
    i_con_cntclr = 1'b0;
    @(negedge i_clk); chk("clr_cnt16", int'(o_cnt_stall), 0); chk("clr_cnt4", int'(s_cnt), 0);
    tick(); drain();

    // async reset in the middle of a stall
    set_d(1, 0, 1, 0, 0, 2, 1, 1); tick();
    set_d(2, 4, 1, 1, 0, 3, 1, 0);
    @(negedge i_clk); chk("pre_rst_stall", int'(o_con_stallF), 1);
    #2 i_nrst = 1'b0;
    #1;
    chk("rst_mid_ctl", int'({o_con_stallF, o_con_stallD, o_con_flushE, o_con_flushD}), 0);
    chk("rst_mid_fwd", int'({o_con_fwdD_rs, o_con_fwdD_rt, o_con_fwdE_rs, o_con_fwdE_rt}), 0);
    chk("rst_mid_cnt", int'(o_cnt_stall), 0);
    @(posedge i_clk);
    #1 i_nrst = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
